// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, widths, reset PC.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: request out; WAIT: granted, awaiting data; HOLD: instruction offered;
  // DISCARD: granted fetch made stale by a redirect, awaiting its response.
  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StDiscard
  } fetch_state_e;

  // Instruction addresses are word aligned; the two low bits are never stored.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/gnt/rvalid side, datapath
// valid/ready side, redirect input and the performance counter.
interface instr_fetch_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import mips_pkg::*;

  logic                 imem_req;
  logic [ADDR_W-1:0]    imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INSTR_W-1:0]   imem_rdata;

  logic                 instr_valid;
  logic [INSTR_W-1:0]   instr;
  logic [ADDR_W-1:0]    instr_pc;
  logic                 instr_ready;

  logic                 redirect_valid;
  logic [ADDR_W-1:0]    redirect_pc;

  logic [CNT_W-1:0]     fetch_cnt;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  // Memory / datapath side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: async reset, word-aligned redirect load, +4 sequential step.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;

  // Redirect load wins over the sequential increment; +4 wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= word_align(RESET_PC);
    end else if (load) begin
      pc_q <= word_align(load_pc);
    end else if (inc) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem fetch at a time, presents
// the fetched word to the datapath and drops stale fetches on redirect.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc;
  logic               pc_inc;
  logic               pc_load;
  logic               capture;
  logic               cnt_inc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [CNT_W-1:0]   cnt_q;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (bus.redirect_pc),
    .pc      (pc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls; a redirect overrides every other event.
  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_load = bus.redirect_valid;
    capture = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (bus.imem_gnt) begin
          state_d = bus.redirect_valid ? StDiscard : StWait;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          if (bus.redirect_valid) begin
            state_d = StFetch;
          end else begin
            capture = 1'b1;
            state_d = StHold;
          end
        end else if (bus.redirect_valid) begin
          state_d = StDiscard;
        end
      end
      StHold: begin
        if (bus.redirect_valid) begin
          state_d = StFetch;
        end else if (bus.instr_ready) begin
          pc_inc  = 1'b1;
          cnt_inc = 1'b1;
          state_d = StFetch;
        end
      end
      StDiscard: begin
        // The stale response always ends the discard; a redirect arriving with
        // it has already retargeted pc, so fetching resumes from the latest target.
        if (bus.imem_rvalid) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Instruction capture on the accepted response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (capture) begin
      instr_q    <= bus.imem_rdata;
      instr_pc_q <= pc;
    end
  end

  // Saturating count of consumed instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request is masked during reset even though the state already reads FETCH.
  assign bus.imem_req    = (state_q == StFetch) && !reset;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state_q == StHold);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage that sits directly upstream of the single-cycle MIPS datapath. It owns the program counter, fetches instruction words from a variable-latency instruction memory over a req/gnt/rvalid handshake, and presents one instruction at a time to the datapath with a valid/ready handshake. It accepts a branch/jump redirect from the datapath and drops any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
CNT_W, 32, width of the retired-fetch performance counter

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch byte address; always equals pc while imem_req=1
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  read data valid; exactly one per granted request, at least 1 cycle after gnt
imem_rdata  in  32  instruction word
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr  out  32  instruction word to datapath (OpCode = instr[31:26])
instr_pc  out  32  address of instr
instr_ready  in  1  datapath consumes instr this cycle
redirect_valid  in  1  taken branch/jump from datapath
redirect_pc  in  32  new fetch address
fetch_cnt  out  CNT_W  count of instructions consumed (valid&ready), saturating

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=FETCH, imem_req=0 while reset asserted, instr_valid=0, instr=0, instr_pc=0, fetch_cnt=0. Reset mid-fetch abandons the transaction; a later rvalid for it is ignored by the new FETCH state (memory is reset by the same signal).
- States: FETCH, WAIT, HOLD, DISCARD.
- FETCH: imem_req=1, imem_addr=pc. gnt=1 -> WAIT. No gnt -> stay.
- WAIT: imem_req=0. rvalid=1 -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, -> HOLD.
- HOLD: instr_valid=1, instr stable. instr_ready=1 -> pc<=pc+4, instr_valid<=0, fetch_cnt++, -> FETCH.
- Latency: gnt in cycle N, rvalid earliest N+1, instr_valid high from N+2. Best-case throughput is one instruction per 3 cycles; no prefetch.
- Redirect (priority over every other event in the same cycle): pc<=redirect_pc with bits[1:0] forced to 0.
  FETCH without gnt -> stay FETCH; the new address is presented next cycle.
  FETCH with gnt in the same cycle -> DISCARD.
  WAIT without rvalid -> DISCARD. WAIT with rvalid -> data dropped, -> FETCH.
  HOLD -> instr_valid<=0, instruction dropped even if instr_ready=1, fetch_cnt unchanged, -> FETCH.
  DISCARD -> pc updated again (the latest redirect wins), remain DISCARD.
- DISCARD: imem_req=0. rvalid=1 -> drop data, -> FETCH. instr_valid=0 throughout.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). fetch_cnt saturates at all ones.
- instr_ready while instr_valid=0 has no effect. imem_gnt/imem_rvalid outside their expected states are ignored.

Decomposition:
- Shared package mips_pkg: fetch state enum (FETCH/WAIT/HOLD/DISCARD), INSTR_W=32, ADDR_W=32, default RESET_PC.
- One natural sub-module: fetch_pc_reg (PC register with async reset, +4 increment, redirect load, alignment masking).
- The FSM and output registers stay in instr_fetch_unit.

Test Plan:
- Reset then gnt/rvalid with zero wait and instr_ready tied high: imem_addr sequence 0,4,8; instr_pc matches; fetch_cnt=3 after three handshakes.
- rvalid delayed 5 cycles and instr_ready held low 4 cycles: instr stays stable with instr_valid=1; no new imem_req until consumed.
- Redirect to 32'h0000_0103 while in WAIT, then rvalid: data dropped, next imem_addr=32'h0000_0100, fetch_cnt unchanged.
- Redirect and instr_ready in the same HOLD cycle: instruction not counted, next imem_addr=redirect target.
- pc=32'hFFFF_FFFC consumed: next imem_addr=0. Preload fetch_cnt to all ones: it stays all ones.
- Assert reset during WAIT: outputs return to reset values immediately; after release, first imem_addr=RESET_PC.
